// File: rtl/prog_delay_line_pkg.sv
// Shared constants and helpers for the programmable delay line.
// Latency floor, latency clamp and per-word even parity.
package prog_delay_line_pkg;

  localparam int LAT_MIN = 3;
  localparam int PAR_W   = 32;

  function automatic int clamp_lat(
    input int lat,
    input int lat_max
  );
    int r;
    r = lat;
    if (lat < LAT_MIN) r = LAT_MIN;
    else if (lat > lat_max) r = lat_max;
    return r;
  endfunction

  // Callers zero-extend narrower words; that leaves the parity unchanged.
  function automatic logic word_parity(
    input logic [PAR_W-1:0] w
  );
    return ^w;
  endfunction

endpackage

// File: rtl/prog_delay_line_sdp_ram_rreg.sv
// Simple dual-port RAM with registered read, read-first on collision.
// Ports: i_clk, i_ena (clock enable), write port i_wr_*, read port i_rd_addr/o_rd_data.
module sdp_ram_rreg #(
  parameter int W  = 40,
  parameter int AW = 5
) (
  input  logic          i_clk,
  input  logic          i_ena,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [W-1:0]  o_rd_data
);

  logic [W-1:0] r_mem [0:(1<<AW)-1];
  logic [W-1:0] r_q;

  // Read-first: at maximum latency the read and the write hit the same
  // address on the same edge, and the old word is the one wanted.
  always_ff @(posedge i_clk) begin
    if (i_ena) begin
      r_mem[i_wr_addr] <= i_wr_data;
      r_q              <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_q;

endmodule

// File: rtl/prog_delay_line.sv
// Parity-protected RAM delay line with run-time programmable latency.
// In: clk, arst_n, ena, din, lat, lat_load, inj_err, err_clr.
// Out: dout, dout_valid, cur_lat, parity_error, err_word.
module prog_delay_line
  import prog_delay_line_pkg::*;
#(
  parameter int BITS_PER_WORD = 9,
  parameter int WORDS         = 4,
  parameter int ADDR_BITS     = 5,
  parameter int LAT_W         = 6
) (
  input  logic                           clk,
  input  logic                           arst_n,
  input  logic                           ena,
  input  logic [BITS_PER_WORD*WORDS-1:0] din,
  input  logic [LAT_W-1:0]               lat,
  input  logic                           lat_load,
  input  logic                           inj_err,
  input  logic                           err_clr,
  output logic [BITS_PER_WORD*WORDS-1:0] dout,
  output logic                           dout_valid,
  output logic [LAT_W-1:0]               cur_lat,
  output logic                           parity_error,
  output logic [WORDS-1:0]               err_word
);

  localparam int DEPTH   = 1 << ADDR_BITS;
  localparam int LAT_MAX = DEPTH + 1;
  localparam int SW      = BITS_PER_WORD + 1;
  localparam int RW      = SW * WORDS;

  localparam logic [ADDR_BITS-1:0] RD_RST =
    ADDR_BITS'(DEPTH - (LAT_MIN - 2));

  logic [1:0]           r_rst_sync;
  logic                 w_rst_n;
  logic [ADDR_BITS-1:0] r_wraddr;
  logic [ADDR_BITS-1:0] r_rdaddr;
  logic [ADDR_BITS-1:0] w_rd_off;
  logic [LAT_W-1:0]     r_cur_lat;
  logic [LAT_W-1:0]     r_fill;
  logic                 r_anchor_pend;
  logic [RW-1:0]        w_wr_data;
  logic [RW-1:0]        w_ram_q;
  logic [RW-1:0]        r_dout_p;
  logic [WORDS-1:0]     w_err_now;
  logic [WORDS-1:0]     r_err_word;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_rst_sync <= '0;
    else         r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  always_comb begin
    w_wr_data = '0;
    for (int i = 0; i < WORDS; i++) begin
      w_wr_data[i*SW +: BITS_PER_WORD] =
        din[i*BITS_PER_WORD +: BITS_PER_WORD];
      w_wr_data[i*SW + BITS_PER_WORD] =
        word_parity(PAR_W'(din[i*BITS_PER_WORD +: BITS_PER_WORD]))
        ^ (inj_err && (i == 0));
    end
  end

  // Two register stages sit after the read address (RAM q, dout),
  // hence the read pointer trails the write pointer by cur_lat-2.
  assign w_rd_off = ADDR_BITS'(r_cur_lat - LAT_W'(2));

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wraddr <= '0;
      r_rdaddr <= RD_RST;
    end else if (ena) begin
      r_wraddr <= r_wraddr + 1'b1;
      r_rdaddr <= r_wraddr - w_rd_off;
    end
  end

  sdp_ram_rreg #(
    .W  (RW),
    .AW (ADDR_BITS)
  ) u_ram (
    .i_clk     (clk),
    .i_ena     (ena),
    .i_wr_addr (r_wraddr),
    .i_wr_data (w_wr_data),
    .i_rd_addr (r_rdaddr),
    .o_rd_data (w_ram_q)
  );

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cur_lat <= LAT_W'(LAT_MIN);
    end else if (lat_load) begin
      r_cur_lat <= LAT_W'(clamp_lat(int'(lat), LAT_MAX));
    end
  end

  // After reset nothing has been written yet, so the first enabled
  // edge acts as the fill anchor, like the edge of a latency load.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_fill        <= '0;
      r_anchor_pend <= 1'b1;
    end else begin
      if (ena) begin
        if (r_anchor_pend) begin
          r_fill        <= '0;
          r_anchor_pend <= 1'b0;
        end else if (r_fill != r_cur_lat) begin
          r_fill <= r_fill + 1'b1;
        end
      end
      if (lat_load) r_fill <= '0;
    end
  end

  assign dout_valid = !r_anchor_pend && (r_fill == r_cur_lat);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_dout_p <= '0;
    else if (ena) r_dout_p <= w_ram_q;
  end

  always_comb begin
    w_err_now = '0;
    for (int i = 0; i < WORDS; i++) begin
      w_err_now[i] = ena && dout_valid &&
        (word_parity(PAR_W'(r_dout_p[i*SW +: BITS_PER_WORD]))
         ^ r_dout_p[i*SW + BITS_PER_WORD]);
    end
  end

  // A fresh error in the clearing cycle survives the clear.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_err_word <= '0;
    else r_err_word <= (err_clr ? '0 : r_err_word) | w_err_now;
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < WORDS; i++) begin
      dout[i*BITS_PER_WORD +: BITS_PER_WORD] =
        r_dout_p[i*SW +: BITS_PER_WORD];
    end
  end

  assign cur_lat      = r_cur_lat;
  assign err_word     = r_err_word;
  assign parity_error = |r_err_word;

endmodule

// File: tb/tb_prog_delay_line.sv
// Testbench for prog_delay_line: beat-history model plus directed checks.
module tb_prog_delay_line;

  localparam int BPW   = 9;
  localparam int WORDS = 4;
  localparam int AW    = 5;
  localparam int LW    = 6;
  localparam int DW    = BPW * WORDS;
  localparam int LMAX  = (1 << AW) + 1;

  logic          clk = 1'b0;
  logic          arst_n = 1'b1;
  logic          ena = 1'b0;
  logic [DW-1:0] din = '0;
  logic [LW-1:0] lat = '0;
  logic          lat_load = 1'b0;
  logic          inj_err = 1'b0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic [LW-1:0] cur_lat;
  logic          parity_error;
  logic [WORDS-1:0] err_word;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  prog_delay_line #(
    .BITS_PER_WORD (BPW),
    .WORDS         (WORDS),
    .ADDR_BITS     (AW),
    .LAT_W         (LW)
  ) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .ena          (ena),
    .din          (din),
    .lat          (lat),
    .lat_load     (lat_load),
    .inj_err      (inj_err),
    .err_clr      (err_clr),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .cur_lat      (cur_lat),
    .parity_error (parity_error),
    .err_word     (err_word)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: every enabled beat is kept in order. A beat written at
  // enabled edge b is on dout after edge b+L; output is valid once
  // L enabled edges have passed since the anchor beat.
  typedef struct packed {
    logic [DW-1:0] d;
    logic          inj;
  } beat_t;

  beat_t hist[$];
  int    m_n = 0;
  int    m_anchor = 0;
  int    m_L = 3;
  bit    m_pend = 1'b1;
  logic [WORDS-1:0] m_err = '0;

  function automatic bit m_valid();
    return !m_pend && (m_n - m_anchor >= m_L);
  endfunction

  function automatic int m_clamp(input int l);
    if (l < 3) return 3;
    if (l > LMAX) return LMAX;
    return l;
  endfunction

  always @(posedge clk or negedge arst_n) begin
    logic [WORDS-1:0] e;
    beat_t b;
    if (!arst_n) begin
      hist.delete();
      m_n = 0;
      m_anchor = 0;
      m_L = 3;
      m_pend = 1'b1;
      m_err = '0;
    end else begin
      e = '0;
      if (ena && m_valid() && hist[m_n - m_L - 1].inj) e[0] = 1'b1;
      m_err = (err_clr ? '0 : m_err) | e;
      if (ena) begin
        b.d = din;
        b.inj = inj_err;
        hist.push_back(b);
        m_n++;
        if (m_pend) begin
          m_anchor = m_n;
          m_pend = 1'b0;
        end
      end
      if (lat_load) begin
        m_L = m_clamp(int'(lat));
        m_anchor = m_n;
      end
    end
  end

  always @(negedge clk) begin
    chk("valid", 64'(dout_valid), 64'(m_valid()));
    chk("cur_lat", 64'(cur_lat), 64'(m_L));
    chk("err_word", 64'(err_word), 64'(m_err));
    chk("parity_error", 64'(parity_error), 64'(|m_err));
    if (m_valid())
      chk("dout", 64'(dout), 64'(hist[m_n - m_L - 1].d));
  end

  function automatic logic [DW-1:0] rep(input int v);
    logic [BPW-1:0] w;
    w = BPW'(v);
    return {WORDS{w}};
  endfunction

  task automatic cyc(input bit e, input logic [DW-1:0] d, input bit ld,
                     input int l, input bit inj, input bit clr);
    ena = e;
    din = d;
    lat_load = ld;
    lat = LW'(l);
    inj_err = inj;
    err_clr = clr;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise;
    int k;
    int en_edges;
    bit e;

    #2 arst_n = 1'b0;
    repeat (3) cyc(0, '0, 0, 0, 0, 0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_valid", 64'(dout_valid), 64'd0);
    chk("rst_cur_lat", 64'(cur_lat), 64'd3);
    chk("rst_err", 64'(err_word), 64'd0);
    arst_n = 1'b1;
    repeat (3) cyc(0, '0, 0, 0, 0, 0);

    // Test 1: latency 10, index stream.
    cyc(1, rep(0), 1, 10, 0, 0);
    chk("t1_valid_after_load", 64'(dout_valid), 64'd0);
    rise = -1;
    for (int i = 1; i <= 40; i++) begin
      cyc(1, rep(i), 0, 0, 0, 0);
      if (dout_valid && rise < 0) rise = i;
      if (i == 20) chk("t1_dout_i20", 64'(dout), 64'(rep(10)));
    end
    chk("t1_rise", 64'(rise), 64'd10);

    // Test 2: same with random stalls.
    cyc(1, rep(0), 1, 10, 0, 0);
    k = 0;
    en_edges = 0;
    rise = -1;
    for (int t = 0; t < 120; t++) begin
      e = 1'($urandom_range(0, 1));
      cyc(e, rep(k + 1), 0, 0, 0, 0);
      if (e) begin
        k++;
        en_edges++;
        if (en_edges == 25) chk("t2_dout", 64'(dout), 64'(rep(15)));
      end
      if (dout_valid && rise < 0) rise = en_edges;
    end
    chk("t2_rise", 64'(rise), 64'd10);

    // Test 3: clamp low and high.
    cyc(1, rep(0), 1, 0, 0, 0);
    chk("t3_lat_lo", 64'(cur_lat), 64'd3);
    for (int i = 1; i <= 10; i++) begin
      cyc(1, rep(i), 0, 0, 0, 0);
      if (i == 8) chk("t3_dout_lo", 64'(dout), 64'(rep(5)));
    end
    cyc(1, rep(0), 1, 40, 0, 0);
    chk("t3_lat_hi", 64'(cur_lat), 64'd33);
    for (int i = 1; i <= 40; i++) begin
      cyc(1, rep(i), 0, 0, 0, 0);
      if (i == 32) chk("t3_valid_32", 64'(dout_valid), 64'd0);
      if (i == 33) chk("t3_valid_33", 64'(dout_valid), 64'd1);
      if (i == 36) chk("t3_dout_hi", 64'(dout), 64'(rep(3)));
    end

    // Test 4: shorten latency while running.
    cyc(1, rep(0), 1, 10, 0, 0);
    repeat (15) cyc(1, DW'({$urandom(), $urandom()}), 0, 0, 0, 0);
    cyc(1, rep(1), 1, 5, 0, 0);
    chk("t4_valid_drop", 64'(dout_valid), 64'd0);
    rise = -1;
    for (int j = 1; j <= 20 && rise < 0; j++) begin
      cyc(1, rep(j + 1), 0, 0, 0, 0);
      if (dout_valid) rise = j;
    end
    chk("t4_rise", 64'(rise), 64'd5);
    chk("t4_no_perr", 64'(parity_error), 64'd0);

    // Test 5: injected parity errors at latency 5.
    cyc(1, rep(77), 0, 0, 1, 0);
    for (int j = 1; j <= 6; j++) begin
      cyc(1, rep(j), 0, 0, 0, 0);
      if (j == 5) begin
        chk("t5_perr_early", 64'(parity_error), 64'd0);
        chk("t5_data_intact", 64'(dout), 64'(rep(77)));
      end
    end
    chk("t5_err_word", 64'(err_word), 64'b0001);
    chk("t5_perr", 64'(parity_error), 64'd1);
    cyc(1, rep(88), 0, 0, 1, 0);
    for (int j = 1; j <= 5; j++) cyc(1, rep(j), 0, 0, 0, 0);
    cyc(1, rep(6), 0, 0, 0, 1);
    chk("t5_clr_vs_new", 64'(err_word), 64'b0001);
    cyc(1, rep(7), 0, 0, 0, 1);
    chk("t5_cleared", 64'(err_word), 64'd0);

    // Test 6: async reset mid-stream with a pending error.
    cyc(1, rep(9), 0, 0, 1, 0);
    for (int j = 1; j <= 6; j++) cyc(1, rep(j), 0, 0, 0, 0);
    chk("t6_pre_err", 64'(parity_error), 64'd1);
    #2 arst_n = 1'b0;
    #1;
    chk("t6_dout0", 64'(dout), 64'd0);
    chk("t6_valid0", 64'(dout_valid), 64'd0);
    chk("t6_perr0", 64'(parity_error), 64'd0);
    chk("t6_lat_min", 64'(cur_lat), 64'd3);
    @(negedge clk);
    repeat (2) cyc(0, '0, 0, 0, 0, 0);
    arst_n = 1'b1;
    repeat (3) cyc(0, '0, 0, 0, 0, 0);
    cyc(1, rep(0), 1, 10, 0, 0);
    rise = -1;
    for (int i = 1; i <= 30; i++) begin
      cyc(1, rep(i), 0, 0, 0, 0);
      if (dout_valid && rise < 0) rise = i;
    end
    chk("t6_rise", 64'(rise), 64'd10);
    chk("t6_no_perr", 64'(parity_error), 64'd0);

    // Random soak against the model.
    for (int t = 0; t < 2000; t++) begin
      cyc($urandom_range(0, 3) != 0,
          DW'({$urandom(), $urandom()}),
          $urandom_range(0, 79) == 0,
          int'($urandom_range(0, 63)),
          $urandom_range(0, 19) == 0,
          $urandom_range(0, 24) == 0);
    end
    cyc(0, '0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
